binary_to_bcd: RTL and testbench
================================

// Module: binary_to_bcd
// PURPOSE
//  Sequential double-dabble converter: binary word in, packed BCD word out.
//  Feeds seven-segment display decoders and the BCD consumers in the display path.
//  Uses one shift-add-3 iteration per clock. Valid/ready handshakes on both sides.
// PARAMETERS
//  BinWidth  8             width of binary input, >= 1
//  Digits    3             BCD digits produced, >= 1
//  Width     Digits*4      derived, packed BCD output width; do not override
// PORTS
//  clk        in   1         single clock, all logic on rising edge
//  rst_n      in   1         synchronous, active-low reset
//  in_valid   in   1         bin holds a value to convert
//  in_ready   out  1         converter idle, accepts bin
//  bin        in   BinWidth  unsigned binary input
//  out_valid  out  1         bcd/overflow hold a finished result
//  out_ready  in   1         consumer takes the result
//  bcd        out  Width     digit i at bcd[i*4+:4], digit 0 = least significant
//  overflow   out  1         value did not fit in Digits digits
// BEHAVIOUR
//  Reset (rst_n low at an edge):
//   - state=IDLE, out_valid=0, bcd=0, overflow=0, iteration count=0.
//   - in_ready=0 while rst_n is low.
//  Reset mid-operation aborts the conversion and discards the partial result; no output is produced.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : in_ready=1. On in_valid&in_ready, at that edge:
//          - load bin into the shift register; clear the BCD accumulator, overflow and count;
//          - go to SHIFT.
//   SHIFT: in_ready=0, out_valid=0. Each edge does one iteration:
//          - every digit >=5 gets +3 (digits are independent);
//          - then shift {bcd_acc, bin_sr} left by 1;
//          - count++.
//          After iteration BinWidth, go to DONE.
//   DONE : out_valid=1; bcd and overflow are registered and held stable.
//          On out_ready, go to IDLE at that edge.
//  Latency: out_valid rises exactly BinWidth edges after the accepting edge.
//  Throughput: one conversion per BinWidth+2 cycles at best (IDLE and DONE each take >=1 cycle).
//  in_ready is never high in DONE; an input cannot be accepted on the same edge a result is taken.
//  in_valid while busy is ignored; the upstream holds it (standard valid/ready).
//  out_valid is held until taken; bcd must not change while out_valid=1 and out_ready=0.
//  Overflow:
//   - set if a 1 shifts out of the top digit during any iteration; sticky within the conversion;
//   - bcd then equals (bin mod 10**Digits); the lower digits are still exact.
//  Arithmetic:
//   - digit correction is 4-bit; a corrected digit is at most 12, so it never exceeds 4 bits;
//   - the iteration counter is $clog2(BinWidth+1) bits;
//   - BinWidth=1: a single iteration; out_valid one edge after accept.
//  bin is sampled only on the accepting edge; later changes have no effect.
// STRUCTURE
//  bcd_pkg (shared):
//   - typedef logic [3:0] bcd_digit_t;
//   - typedef enum {IDLE, SHIFT, DONE} b2b_state_t;
//   - function digits_for(int bin_width) returns the minimum digits needed.
//  Sub-module bcd_add3_digit: combinational, bcd_digit_t in -> corrected bcd_digit_t out.
//  The top level instantiates one bcd_add3_digit per digit with a generate loop.
//  Elaboration-time warning if Digits < digits_for(BinWidth) (overflow possible, not an error).
// TESTING
//  1 Reset, then bin=8'd0 -> after 8 edges: out_valid=1, bcd=12'h000, overflow=0.
//  2 bin=8'd255 (Digits=3) -> bcd=12'h255, overflow=0, out_valid exactly 8 edges after accept.
//  3 Digits=2, bin=8'd255 -> bcd=8'h55, overflow=1; bin=8'd99 -> bcd=8'h99, overflow=0.
//  4 Backpressure: bin=8'd173, out_ready=0 for 20 cycles
//     -> bcd=12'h173 stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
//  5 in_valid held high with a new bin during SHIFT -> ignored;
//     next value accepted only after the result is taken (in_ready=1).
//  6 rst_n low for 1 cycle at iteration 4 of bin=8'd200
//     -> out_valid stays 0, bcd=0, IDLE; a new bin=8'd42 then gives bcd=12'h042.
//  Sweep: all 256 inputs checked against a reference model.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the binary-to-BCD conversion path.
//   bcd_digit_t  : one packed BCD digit (0..9 when valid, up to 12 transiently)
//   b2b_state_t  : converter FSM states
//   digits_for() : minimum number of decimal digits needed to represent any
//                  unsigned value of a given binary width
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    // Counts decimal digits of the largest value (2**bin_width - 1).
    // Widths of 64 and above saturate to the all-ones 64-bit value, which is
    // far beyond any realistic display path.
    function automatic int digits_for(input int bin_width);
        longint unsigned max_val;
        int              d;
        if (bin_width >= 64) begin
            max_val = '1;
        end else begin
            max_val = (64'd1 << bin_width) - 64'd1;
        end
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= 64'd10) begin
                max_val = max_val / 64'd10;
                d       = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// -----------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for a single BCD digit: a digit of
// 5 or more gets +3 so that the following left shift carries into the next
// decimal position.
// Ports:
//   digit      in   bcd_digit_t   digit before correction
//   corrected  out  bcd_digit_t   digit after correction (at most 12)
// -----------------------------------------------------------------------------
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    // Input never exceeds 9 in normal operation, so the 4-bit sum cannot wrap.
    always_comb begin
        corrected = digit;
        if (digit >= 4'd5) begin
            corrected = digit + 4'd3;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// -----------------------------------------------------------------------------
// binary_to_bcd
// Sequential double-dabble converter: one shift-add-3 iteration per clock.
// An unsigned binary word is accepted on the input handshake and, BinWidth
// edges later, a packed BCD result is presented on the output handshake.
//
// Parameters:
//   BinWidth  width of the binary input (>= 1)
//   Digits    number of BCD digits produced (>= 1)
//   Width     packed BCD width, derived as Digits*4 (do not override)
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous active-low reset
//   in_valid   in   1         bin holds a value to convert
//   in_ready   out  1         converter idle, accepts bin
//   bin        in   BinWidth  unsigned binary input
//   out_valid  out  1         bcd/overflow hold a finished result
//   out_ready  in   1         consumer takes the result
//   bcd        out  Width     digit i at bcd[i*4+:4], digit 0 least significant
//   overflow   out  1         value did not fit in Digits digits
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and its data) until that edge; ready
// may depend on state but never on the partner's valid. in_ready is high only
// in IDLE and out_valid only in DONE, so a result is never taken on the same
// edge that a new input is accepted.
// -----------------------------------------------------------------------------
module binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int BinWidth = 8,
    parameter int Digits   = 3,
    parameter int Width    = Digits * 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BinWidth-1:0] bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Width-1:0]    bcd,
    output logic                overflow
);

    localparam int              CntW     = $clog2(BinWidth + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(BinWidth - 1);

    // Undersized digit counts are legal: the result is then bin mod 10**Digits
    // and overflow flags it. This is reported for information only.
    if (Digits < digits_for(BinWidth)) begin : g_range_note
        $info("binary_to_bcd: Digits=%0d is below the %0d needed for BinWidth=%0d; large inputs will set overflow",
              Digits, digits_for(BinWidth), BinWidth);
    end

    b2b_state_t            state;
    b2b_state_t            state_next;
    logic [BinWidth-1:0]   bin_sr;
    logic [Width-1:0]      bcd_acc;
    logic [Width-1:0]      corrected;
    logic                  overflow_r;
    logic [CntW-1:0]       count;

    // One add-3 corrector per digit; digits are corrected independently.
    for (genvar i = 0; i < Digits; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit     (bcd_acc[i*4 +: 4]),
            .corrected (corrected[i*4 +: 4])
        );
    end

    // in_ready is forced low during reset so nothing is accepted while the
    // converter is being cleared.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd       = bcd_acc;
    assign overflow  = overflow_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // count holds the number of iterations already completed, so
                // this edge performs the final one.
                if (count == LastIter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate in SHIFT, hold otherwise (including
    // DONE, which keeps bcd/overflow stable under backpressure).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sr     <= '0;
            bcd_acc    <= '0;
            overflow_r <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr     <= bin;
                        bcd_acc    <= '0;
                        overflow_r <= 1'b0;
                        count      <= '0;
                    end
                end
                SHIFT: begin
                    // {bcd_acc, bin_sr} shifted left by one after correction.
                    // The bit leaving the top digit is worth 10**Digits; it is
                    // dropped and remembered as overflow, leaving the lower
                    // digits exact.
                    bcd_acc    <= {corrected[Width-2:0], bin_sr[BinWidth-1]};
                    bin_sr     <= bin_sr << 1;
                    overflow_r <= overflow_r | corrected[Width-1];
                    count      <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digits=3 instance (full range for 8-bit input)
    logic        iv3, ir3, ov3, or3, of3;
    logic [7:0]  b3;
    logic [11:0] bcd3;

    // Digits=2 instance (overflow behaviour)
    logic        iv2, ir2, ov2, or2, of2;
    logic [7:0]  b2;
    logic [7:0]  bcd2;

    binary_to_bcd #(.BinWidth(8), .Digits(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .bin       (b3),
        .out_valid (ov3),
        .out_ready (or3),
        .bcd       (bcd3),
        .overflow  (of3)
    );

    binary_to_bcd #(.BinWidth(8), .Digits(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .bin       (b2),
        .out_valid (ov2),
        .out_ready (or2),
        .bcd       (bcd2),
        .overflow  (of2)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int errors   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of v modulo 10**digits, computed arithmetically.
    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        iv3 = 1'b0; or3 = 1'b0; b3 = '0;
        iv2 = 1'b0; or2 = 1'b0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready3_low", 32'(ir3), 32'd0);
        rst_n = 1'b1;
        #1;
    endtask

    // Waits (bounded) for in_ready, presents v, and returns #1 after the accept edge.
    task automatic start(input int sel, input logic [7:0] v);
        int guard;
        guard = 0;
        while (!((sel == 3) ? ir3 : ir2) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("start_in_ready", 32'((sel == 3) ? ir3 : ir2), 32'd1);
        if (sel == 3) begin iv3 = 1'b1; b3 = v; end
        else          begin iv2 = 1'b1; b2 = v; end
        @(posedge clk); #1;
        // bin is only sampled on the accept edge; scramble it afterwards.
        if (sel == 3) begin iv3 = 1'b0; b3 = 8'($urandom_range(0, 255)); end
        else          begin iv2 = 1'b0; b2 = 8'($urandom_range(0, 255)); end
    endtask

    // Counts edges from the accept edge until out_valid (bounded).
    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        while (!((sel == 3) ? ov3 : ov2) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input int sel);
        if (sel == 3) or3 = 1'b1; else or2 = 1'b1;
        @(posedge clk); #1;
        if (sel == 3) or3 = 1'b0; else or2 = 1'b0;
    endtask

    task automatic convert(input int sel, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic exp_ovf,
                           input string name);
        int lat;
        start(sel, v);
        wait_done(sel, lat);
        check({name, "_latency"}, 32'(lat), 32'd8);
        if (sel == 3) begin
            check({name, "_bcd"}, 32'(bcd3), 32'(exp_bcd));
            check({name, "_ovf"}, 32'(of3), 32'(exp_ovf));
        end else begin
            check({name, "_bcd"}, 32'(bcd2), 32'(exp_bcd[7:0]));
            check({name, "_ovf"}, 32'(of2), 32'(exp_ovf));
        end
        take(sel);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int          lat;
        bit          stable;
        logic [11:0] exp;

        vecs[0] = '{8'd0,   12'h000, 1'b0};
        vecs[1] = '{8'd255, 12'h255, 1'b0};
        vecs[2] = '{8'd1,   12'h001, 1'b0};
        vecs[3] = '{8'd9,   12'h009, 1'b0};
        vecs[4] = '{8'd10,  12'h010, 1'b0};
        vecs[5] = '{8'd99,  12'h099, 1'b0};
        vecs[6] = '{8'd100, 12'h100, 1'b0};
        vecs[7] = '{8'd128, 12'h128, 1'b0};
        vecs[8] = '{8'd173, 12'h173, 1'b0};
        vecs[9] = '{8'd200, 12'h200, 1'b0};

        // 1: reset state, then zero
        do_reset();
        check("reset_out_valid", 32'(ov3), 32'd0);
        check("reset_bcd",       32'(bcd3), 32'd0);
        check("reset_overflow",  32'(of3), 32'd0);
        check("reset_in_ready",  32'(ir3), 32'd1);
        convert(3, 8'd0, 12'h000, 1'b0, "zero");

        // 2 and table: directed values including 255 on Digits=3
        for (int i = 0; i < 10; i++) begin
            convert(3, vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // 3: Digits=2 overflow and in-range cases
        convert(2, 8'd255, 12'h055, 1'b1, "d2_255");
        convert(2, 8'd99,  12'h099, 1'b0, "d2_99");
        convert(2, 8'd100, 12'h000, 1'b1, "d2_100");
        convert(2, 8'd42,  12'h042, 1'b0, "d2_42");

        // 4: backpressure, with in_valid pushed throughout
        start(3, 8'd173);
        wait_done(3, lat);
        check("bp_latency", 32'(lat), 32'd8);
        iv3 = 1'b1; b3 = 8'd5;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bcd3 !== 12'h173 || ov3 !== 1'b1 || ir3 !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_stable_held", 32'(stable), 32'd1);
        iv3 = 1'b0;
        take(3);
        check("bp_idle_out_valid", 32'(ov3), 32'd0);
        check("bp_idle_in_ready",  32'(ir3), 32'd1);

        // 5: in_valid held with a new value while busy -> ignored until taken
        start(3, 8'd100);
        iv3 = 1'b1; b3 = 8'd77;
        stable = 1'b1;
        lat = 0;
        while (!ov3 && lat < 40) begin
            if (ir3 !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_in_ready_low", 32'(stable), 32'd1);
        check("busy_latency",      32'(lat), 32'd8);
        check("busy_first_bcd",    32'(bcd3), 32'h100);
        take(3);
        check("busy_ready_after_take", 32'(ir3), 32'd1);
        @(posedge clk); #1;          // 77 accepted here
        iv3 = 1'b0;
        check("busy_second_accepted", 32'(ir3), 32'd0);
        wait_done(3, lat);
        check("busy_second_latency", 32'(lat), 32'd8);
        check("busy_second_bcd",     32'(bcd3), 32'h077);
        take(3);

        // 6: reset during iteration 4 of 200
        start(3, 8'd200);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready_low", 32'(ir3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midreset_bcd",      32'(bcd3), 32'd0);
        check("midreset_overflow", 32'(of3), 32'd0);
        check("midreset_idle",     32'(ir3), 32'd1);
        stable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ov3 !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        check("midreset_no_output", 32'(stable), 32'd1);
        convert(3, 8'd42, 12'h042, 1'b0, "after_reset_42");

        // Sweep: every input on both instances against the arithmetic model
        for (int v = 0; v < 256; v++) begin
            exp = ref_bcd(v, 3);
            convert(3, 8'(v), exp, 1'b0, $sformatf("sweep3_%0d", v));
        end
        for (int v = 0; v < 256; v++) begin
            exp = ref_bcd(v, 2);
            convert(2, 8'(v), exp, (v >= 100) ? 1'b1 : 1'b0, $sformatf("sweep2_%0d", v));
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
